// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the clock gating controller.
// Holds the controller state enum and the gate event counter width.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } state_e;

    localparam int GateCntW = 16;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Request/status bundle between the gated-domain requester and the gating controller.
// The master drives config, busy and request; the slave returns ready, enable and status.
interface clk_gate_ctrl_if
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IdleCntW = 8
);
    logic                cfg_en_i;
    logic [IdleCntW-1:0] idle_thresh_i;
    logic                busy_i;
    logic                req_valid_i;
    logic                req_ready_o;
    logic                gate_en_o;
    logic                gated_o;
    logic [GateCntW-1:0] gate_cnt_o;

    modport master (
        output cfg_en_i, idle_thresh_i, busy_i, req_valid_i,
        input  req_ready_o, gate_en_o, gated_o, gate_cnt_o
    );

    modport slave (
        input  cfg_en_i, idle_thresh_i, busy_i, req_valid_i,
        output req_ready_o, gate_en_o, gated_o, gate_cnt_o
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Auto clock gating controller: stops the domain clock after a programmable idle run
// and restarts it with a fixed warm-up before requests are accepted again.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IdleCntW   = 8,
    parameter int WakeCycles = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    clk_gate_ctrl_if.slave bus
);

    localparam logic [3:0] WakeLoad = 4'(WakeCycles - 1);

    state_e              state_q, state_d;
    logic [IdleCntW-1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]          wake_cnt_q, wake_cnt_d;
    logic [GateCntW-1:0] gate_cnt_q, gate_cnt_d;

    logic idle;
    logic goto_gate;
    logic wake_req;

    function automatic logic [IdleCntW-1:0] idle_sat_inc(input logic [IdleCntW-1:0] v);
        return (&v) ? v : v + IdleCntW'(1);
    endfunction

    function automatic logic [GateCntW-1:0] gate_sat_inc(input logic [GateCntW-1:0] v);
        return (&v) ? v : v + GateCntW'(1);
    endfunction

    // A pending request counts as activity, so it always wins over the gating decision.
    assign idle      = bus.cfg_en_i & ~bus.busy_i & ~bus.req_valid_i;
    assign goto_gate = idle & (idle_cnt_q >= bus.idle_thresh_i);
    assign wake_req  = bus.req_valid_i | bus.busy_i | ~bus.cfg_en_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            gate_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (goto_gate) state_d = GATED;
            GATED:   if (wake_req) state_d = WAKE;
            WAKE:    if (wake_cnt_q == 4'd0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        gate_cnt_d = gate_cnt_q;
        unique case (state_q)
            RUN: begin
                if (!idle) begin
                    idle_cnt_d = '0;
                end else if (goto_gate) begin
                    idle_cnt_d = '0;
                    gate_cnt_d = gate_sat_inc(gate_cnt_q);
                end else begin
                    idle_cnt_d = idle_sat_inc(idle_cnt_q);
                end
            end
            GATED:   if (wake_req) wake_cnt_d = WakeLoad;
            WAKE:    if (wake_cnt_q != 4'd0) wake_cnt_d = wake_cnt_q - 4'd1;
            default: idle_cnt_d = '0;
        endcase
    end

    // Enable is a pure decode of the registered state, so it only moves on a rising edge.
    always_comb begin
        bus.gate_en_o   = 1'b1;
        bus.req_ready_o = 1'b0;
        bus.gated_o     = 1'b0;
        unique case (state_q)
            RUN:   bus.req_ready_o = 1'b1;
            GATED: begin
                bus.gate_en_o = 1'b0;
                bus.gated_o   = 1'b1;
            end
            WAKE:    bus.gate_en_o = 1'b1;
            default: bus.req_ready_o = 1'b1;
        endcase
    end

    assign bus.gate_cnt_o = gate_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the gating rules.
module tb_clk_gate_ctrl;
    import clk_gate_ctrl_pkg::*;

    localparam int IdleCntW   = 8;
    localparam int WakeCycles = 2;
    localparam int IdleMax    = (1 << IdleCntW) - 1;
    localparam int GateMax    = 65535;

    logic clk = 1'b0;
    logic rst;

    clk_gate_ctrl_if #(.IdleCntW(IdleCntW)) bus ();

    clk_gate_ctrl #(
        .IdleCntW  (IdleCntW),
        .WakeCycles(WakeCycles)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: clock stopped flag, warm-up cycles still to run, current idle run, gate events.
    bit m_stop  = 1'b0;
    int m_wake  = 0;
    int m_idle  = 0;
    int m_gates = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_en();
        return m_stop ? 0 : 1;
    endfunction

    function automatic int exp_rdy();
        return (!m_stop && m_wake == 0) ? 1 : 0;
    endfunction

    function automatic int exp_gated();
        return m_stop ? 1 : 0;
    endfunction

    task automatic model_step();
        bit is_idle;
        if (rst) begin
            m_stop = 1'b0;
            m_wake = 0;
            m_idle = 0;
            m_gates = 0;
            return;
        end
        is_idle = bus.cfg_en_i && !bus.busy_i && !bus.req_valid_i;
        if (m_wake > 0) begin
            m_wake = m_wake - 1;
        end else if (m_stop) begin
            if (bus.req_valid_i || bus.busy_i || !bus.cfg_en_i) begin
                m_stop = 1'b0;
                m_wake = WakeCycles;
            end
        end else if (!is_idle) begin
            m_idle = 0;
        end else if (m_idle >= int'(bus.idle_thresh_i)) begin
            m_stop  = 1'b1;
            m_idle  = 0;
            m_gates = (m_gates < GateMax) ? m_gates + 1 : GateMax;
        end else begin
            m_idle = (m_idle < IdleMax) ? m_idle + 1 : IdleMax;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("gate_en", 32'(bus.gate_en_o), exp_en());
        check("req_ready", 32'(bus.req_ready_o), exp_rdy());
        check("gated", 32'(bus.gated_o), exp_gated());
        check("gate_cnt", 32'(bus.gate_cnt_o), m_gates);
    endtask

    task automatic drive(input bit cfg, input int thr, input bit busy, input bit valid);
        bus.cfg_en_i      = cfg;
        bus.idle_thresh_i = IdleCntW'(thr);
        bus.busy_i        = busy;
        bus.req_valid_i   = valid;
    endtask

    initial begin
        bit cur_rdy;
        bit hold;
        int thr;

        rst = 1'b1;
        drive(1'b1, 4, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_gate_en", 32'(bus.gate_en_o), 1);
        check("rst_ready", 32'(bus.req_ready_o), 1);
        check("rst_gated", 32'(bus.gated_o), 0);
        check("rst_cnt", 32'(bus.gate_cnt_o), 0);
        rst = 1'b0;

        // Threshold 4 with a quiet domain: clock stops on the fifth idle cycle.
        for (int i = 0; i < 4; i++) tick();
        check("t4_still_run", 32'(bus.gate_en_o), 1);
        tick();
        check("t4_gate_en", 32'(bus.gate_en_o), 0);
        check("t4_gated", 32'(bus.gated_o), 1);
        check("t4_cnt", 32'(bus.gate_cnt_o), 1);

        // Request while gated: enable returns next cycle, ready three cycles after valid.
        drive(1'b1, 4, 1'b0, 1'b1);
        tick();
        check("wake_en", 32'(bus.gate_en_o), 1);
        check("wake_rdy1", 32'(bus.req_ready_o), 0);
        tick();
        check("wake_rdy2", 32'(bus.req_ready_o), 0);
        tick();
        check("wake_rdy3", 32'(bus.req_ready_o), 1);
        tick();
        drive(1'b1, 3, 1'b0, 1'b0);

        // Threshold 3, request on the matching cycle keeps the clock running.
        for (int i = 0; i < 3; i++) tick();
        drive(1'b1, 3, 1'b0, 1'b1);
        tick();
        check("prio_gated", 32'(bus.gated_o), 0);
        check("prio_cnt", 32'(bus.gate_cnt_o), 1);
        drive(1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("prio_cleared", 32'(bus.gated_o), 0);
        tick();
        check("prio_regate", 32'(bus.gated_o), 1);
        check("prio_regate_cnt", 32'(bus.gate_cnt_o), 2);

        drive(1'b1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        drive(1'b1, 0, 1'b0, 1'b0);

        // Threshold 0 gates right after the first idle cycle.
        tick();
        check("t0_gated", 32'(bus.gated_o), 1);
        check("t0_cnt", 32'(bus.gate_cnt_o), 3);
        drive(1'b1, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();

        // Gating disabled: the enable must never drop.
        for (int i = 0; i < 1000; i++) begin
            drive(1'b0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            check("noen_gate_en", 32'(bus.gate_en_o), 1);
        end

        // Reset during WAKE and during GATED.
        drive(1'b1, 0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 1'b1, 1'b0);
        tick();
        check("pre_rst_wake_rdy", 32'(bus.req_ready_o), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_en", 32'(bus.gate_en_o), 1);
        check("rstw_rdy", 32'(bus.req_ready_o), 1);
        check("rstw_cnt", 32'(bus.gate_cnt_o), 0);
        drive(1'b1, 0, 1'b0, 1'b0);
        tick();
        check("pre_rst_gated", 32'(bus.gated_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstg_en", 32'(bus.gate_en_o), 1);
        check("rstg_rdy", 32'(bus.req_ready_o), 1);
        check("rstg_cnt", 32'(bus.gate_cnt_o), 0);

        // Randomized traffic; a raised request is held until it is accepted.
        cur_rdy = 1'b1;
        thr = 2;
        for (int i = 0; i < 3000; i++) begin
            hold = bus.req_valid_i && !cur_rdy;
            if (i % 200 == 0) thr = ($urandom_range(0, 15) == 0) ? 200 : int'($urandom_range(0, 6));
            drive(1'($urandom_range(0, 31) != 0), thr,
                  1'($urandom_range(0, 7) == 0),
                  hold ? 1'b1 : 1'($urandom_range(0, 7) == 0));
            rst = ($urandom_range(0, 499) == 0);
            cur_rdy = bus.req_ready_o;
            tick();
        end
        rst = 1'b0;

        // Saturation: preload the event counter near the top, then keep gating.
        drive(1'b1, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        force dut.gate_cnt_q = 16'hFFFC;
        m_gates = 65532;
        tick();
        release dut.gate_cnt_q;
        check("sat_preload", 32'(bus.gate_cnt_o), 32'hFFFC);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 0, 1'b0, 1'b0);
            tick();
            check("sat_cnt", 32'(bus.gate_cnt_o), (65533 + k > GateMax) ? GateMax : 65533 + k);
            drive(1'b1, 0, 1'b1, 1'b0);
            for (int j = 0; j < 3; j++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IdleCntW, default 8, width of idle counter and threshold.
REQ-002 SHALL have parameter WakeCycles, default 2, legal range 1..15; cycles of running clock before requests are accepted after wake.
REQ-003 SHALL have port clk_i  input  1  sole clock, ungated free-running.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_en_i  input  1  1 = auto clock gating permitted.
REQ-006 SHALL have port idle_thresh_i  input  IdleCntW  idle cycles required before gating.
REQ-007 SHALL have port busy_i  input  1  gated domain has work in flight.
REQ-008 SHALL have port req_valid_i  input  1  request pending for gated domain.
REQ-009 SHALL have port req_ready_o  output  1  request accepted this cycle (valid & ready).
REQ-010 SHALL have port gate_en_o  output  1  enable to downstream clock gating cell en_i.
REQ-011 SHALL have port gated_o  output  1  status: domain clock currently stopped.
REQ-012 SHALL have port gate_cnt_o  output  16  saturating count of RUN->GATED transitions.

Function
REQ-013 SHALL implement FSM states RUN, GATED, WAKE; all outputs registered or decoded from registered state only.
REQ-014 SHALL in RUN drive gate_en_o=1, req_ready_o=1, gated_o=0.
REQ-015 SHALL define idle = cfg_en_i & ~busy_i & ~req_valid_i; in RUN, idle increments idle_cnt (saturating at all-ones), ~idle clears idle_cnt to 0.
REQ-016 SHALL transition RUN->GATED when idle & (idle_cnt >= idle_thresh_i), comparing against the live threshold; threshold 0 gates the cycle after the first idle cycle.
REQ-017 SHALL clear idle_cnt on entering GATED and increment gate_cnt_o (saturating at 16'hFFFF).
REQ-018 SHALL in GATED drive gate_en_o=0, req_ready_o=0, gated_o=1.
REQ-019 SHALL transition GATED->WAKE when req_valid_i | busy_i | ~cfg_en_i, loading wake_cnt with WakeCycles-1.
REQ-020 SHALL in WAKE drive gate_en_o=1, req_ready_o=0, gated_o=0; decrement wake_cnt each cycle; WAKE->RUN when wake_cnt==0.
REQ-021 SHALL give req_valid_i priority over the gating decision: request coincident with threshold match keeps RUN, clears idle_cnt.
REQ-022 SHALL never gate while cfg_en_i=0; deasserting cfg_en_i in RUN clears idle_cnt, in WAKE has no effect on wake sequence.
REQ-023 SHALL keep req_valid_i hold semantics: requester holds valid until req_ready_o; latency GATED+valid to ready = WakeCycles+1 cycles.
REQ-024 SHALL not depend on busy_i while GATED except as wake source (glitch-free enable: gate_en_o changes only on clk_i rising edge).

Reset
REQ-025 SHALL on rst_i=1 at a rising edge enter RUN, idle_cnt=0, wake_cnt=0, gate_cnt_o=0, gate_en_o=1, req_ready_o=1, gated_o=0.
REQ-026 SHALL treat reset asserted in GATED or WAKE identically: clock enabled next cycle, no wake delay applied.

Structure
REQ-027 SHALL place the state enum (RUN, GATED, WAKE) and gate-count width constant in package clk_gate_ctrl_pkg.
REQ-028 SHALL be a single module with no sub-modules; output gate_en_o connects directly to the existing latch-based clock gating cell en_i.

Verification
REQ-029 SHALL cover: cfg_en_i=1, thresh=4, busy/valid low -> gate_en_o falls after 5 idle cycles, gated_o=1, gate_cnt_o=1.
REQ-030 SHALL cover: GATED, req_valid_i=1 held, WakeCycles=2 -> gate_en_o=1 next cycle, req_ready_o=1 exactly 3 cycles after valid asserted.
REQ-031 SHALL cover: thresh=3, req_valid_i pulse on the threshold-match cycle -> stay RUN, idle_cnt=0, gate_cnt_o unchanged.
REQ-032 SHALL cover: thresh=0 -> GATED one cycle after first idle cycle; cfg_en_i=0 throughout -> gate_en_o stays 1 for 1000 cycles.
REQ-033 SHALL cover: rst_i asserted in WAKE and in GATED -> next cycle RUN, gate_en_o=1, req_ready_o=1, gate_cnt_o=0.
REQ-034 SHALL cover: 65540 gate/wake cycles forced -> gate_cnt_o saturates at 16'hFFFF.
